// File: rtl/dmem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit_if
// Description : CPU request/response and data-memory signal bundle for the
//               data-memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_data_out;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_data_in, mem_write, mem_read
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_data_in, mem_write, mem_read
    );
endinterface
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit
// Description : Byte/halfword/word load-store initiator for a word-addressed
//               data memory, with read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
    parameter int DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    dmem_access_unit_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_unsigned;
    logic        r_error;

    logic        w_err;
    logic [31:0] w_idx;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_idx = {2'b00, bus.req_addr[31:2]};

    always_comb begin
        w_err = 1'b0;
        if (bus.req_size == 2'b11)                                w_err = 1'b1;
        if (bus.req_size == 2'b01 && bus.req_addr[0] != 1'b0)     w_err = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)  w_err = 1'b1;
        if (w_idx >= 32'(DEPTH))                                  w_err = 1'b1;
    end

    // Lane extraction and merge both work on the word captured in READ.
    always_comb begin
        w_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_word[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = r_word;
        endcase
    end

    always_comb begin
        w_merge = r_word;
        case (r_size)
            2'b00:   w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b01:   w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
            r_size     <= '0;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr     <= bus.req_addr;
                        r_wdata    <= bus.req_wdata;
                        r_size     <= bus.req_size;
                        r_write    <= bus.req_write;
                        r_unsigned <= bus.req_unsigned;
                        r_error    <= w_err;
                        r_word     <= '0;
                        if (w_err)
                            r_state <= S_RESP;
                        else if (bus.req_write && bus.req_size == 2'b10)
                            r_state <= S_WRITE;
                        else
                            r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_word  <= bus.mem_data_out;
                    r_state <= r_write ? S_WRITE : S_RESP;
                end
                S_WRITE: r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Everything below depends on registered state only; rst gates req_ready.
    assign bus.req_ready   = (r_state == S_IDLE) && !rst;
    assign bus.mem_read    = (r_state == S_READ);
    assign bus.mem_write   = (r_state == S_WRITE);
    assign bus.mem_address = (r_state == S_READ || r_state == S_WRITE) ? {2'b00, r_addr[31:2]} : 32'd0;
    assign bus.mem_data_in = (r_state == S_WRITE) ? w_merge : 32'd0;
    assign bus.resp_valid  = (r_state == S_RESP);
    assign bus.resp_error  = (r_state == S_RESP) && r_error;
    assign bus.resp_rdata  = (r_state == S_RESP && !r_error && !r_write) ? w_load : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_unit
// Description : Vector-table bench for dmem_access_unit with a behavioural
//               word memory and hand-written reset and streaming sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wword;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    dmem_access_unit_if bus();

    dmem_access_unit #(.DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:255];

    initial begin
        for (int k = 0; k < 256; k++) mem[k] <= 32'd0;
        mem[4] <= 32'h8899AABB;
    end

    always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[7:0]] <= bus.mem_data_in;
    assign bus.mem_data_out = mem[bus.mem_address[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
        end
        if (!ok) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat = 0, nrd = 0, nwr = 0;
        logic [31:0] rdata = '0, wword = '0, raddr = '0;
        logic        err = 1'b0, overlap = 1'b0;
        bit          seen = 1'b0;
        string       n;
        n = $sformatf("v%0d", idx);
        wait_ready(n);
        drive(v.wr, v.sz, v.uns, v.addr, v.wdata);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (bus.mem_read)  begin nrd++; raddr = bus.mem_address; end
            if (bus.mem_write) begin nwr++; wword = bus.mem_data_in; end
            if (bus.mem_read && bus.mem_write) overlap = 1'b1;
            if (bus.resp_valid) begin
                seen = 1'b1; lat = c; rdata = bus.resp_rdata; err = bus.resp_error;
            end
        end
        chk({n, "_lat"},     32'(lat), 32'(v.lat));
        chk({n, "_rdata"},   rdata,    v.rdata);
        chk({n, "_err"},     32'(err), 32'(v.err));
        chk({n, "_nread"},   32'(nrd), 32'(v.nrd));
        chk({n, "_nwrite"},  32'(nwr), 32'(v.nwr));
        chk({n, "_overlap"}, 32'(overlap), 32'd0);
        if (v.nwr > 0) chk({n, "_wword"}, wword, v.wword);
        if (v.nrd > 0) chk({n, "_raddr"}, raddr, {2'b00, v.addr[31:2]});
    endtask

    vec_t vecs [18];
    logic [31:0] sexp [4];

    initial begin
        //          wr    sz     uns   addr          wdata         rdata         err  lat rd wr wword
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h013,     32'h0,        32'hFFFFFF88, 1'b0, 2, 1, 0, 32'h0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h013,     32'h0,        32'h00000088, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h012,     32'h0,        32'hFFFF8899, 1'b0, 2, 1, 0, 32'h0};
        vecs[3]  = '{1'b0, 2'b10, 1'b1, 32'h010,     32'h0,        32'h8899AABB, 1'b0, 2, 1, 0, 32'h0};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h011,     32'h12345678, 32'h0,        1'b0, 3, 1, 1, 32'h889978BB};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h010,     32'h0,        32'h889978BB, 1'b0, 2, 1, 0, 32'h0};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h011,     32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h012,     32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h010,     32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h400,     32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h010,     32'h0,        32'h889978BB, 1'b0, 2, 1, 0, 32'h0};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h010,     32'h0,        32'h000078BB, 1'b0, 2, 1, 0, 32'h0};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h010,     32'h0,        32'hFFFFFFBB, 1'b0, 2, 1, 0, 32'h0};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h012,     32'h0000CAFE, 32'h0,        1'b0, 3, 1, 1, 32'hCAFE78BB};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h3FC,     32'h01020304, 32'h0,        1'b0, 2, 0, 1, 32'h01020304};
        vecs[15] = '{1'b0, 2'b00, 1'b1, 32'h3FF,     32'h0,        32'h00000001, 1'b0, 2, 1, 0, 32'h0};
        vecs[16] = '{1'b0, 2'b01, 1'b0, 32'h3FE,     32'h0,        32'h00000102, 1'b0, 2, 1, 0, 32'h0};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h010,     32'h0,        32'hCAFE78BB, 1'b0, 2, 1, 0, 32'h0};

        bus.req_valid = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready",      32'(bus.req_ready),  32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mem_write",  32'(bus.mem_write),  32'd0);
        chk("rst_mem_read",   32'(bus.mem_read),   32'd0);
        chk("rst_mem_addr",   bus.mem_address,     32'd0);
        chk("rst_mem_din",    bus.mem_data_in,     32'd0);
        chk("rst_rdata",      bus.resp_rdata,      32'd0);
        rst = 1'b0;
        #1 chk("rst_release_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Reset during WRITE must suppress the memory write and the response.
        begin
            bit saw = 1'b0;
            wait_ready("rstw");
            drive(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
            bus.req_valid = 1'b1;
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            chk("rstw_write_before", 32'(bus.mem_write), 32'd1);
            #3 rst = 1'b1;
            #1;
            chk("rstw_write_drop", 32'(bus.mem_write), 32'd0);
            chk("rstw_din_drop",   bus.mem_data_in,    32'd0);
            chk("rstw_ready_low",  32'(bus.req_ready), 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            #1 chk("rstw_ready_after", 32'(bus.req_ready), 32'd1);
            chk("rstw_mem_kept", mem[4], 32'hCAFE78BB);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (bus.resp_valid) saw = 1'b1;
            end
            chk("rstw_no_resp", 32'(saw), 32'd0);
        end

        // Streaming: req_valid held high, alternating stores and loads.
        begin
            vec_t sq [4];
            int   acc = 0, nresp = 0, extra = 0;
            bit   rdy;
            sq[0] = '{1'b1, 2'b10, 1'b0, 32'h020, 32'h11111111, 32'h0, 1'b0, 0, 0, 0, 32'h0};
            sq[1] = '{1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        32'h0, 1'b0, 0, 0, 0, 32'h0};
            sq[2] = '{1'b1, 2'b00, 1'b0, 32'h021, 32'h000000AA, 32'h0, 1'b0, 0, 0, 0, 32'h0};
            sq[3] = '{1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        32'h0, 1'b0, 0, 0, 0, 32'h0};
            sexp[0] = 32'h0; sexp[1] = 32'h11111111; sexp[2] = 32'h0; sexp[3] = 32'h1111AA11;
            wait_ready("strm");
            drive(sq[0].wr, sq[0].sz, sq[0].uns, sq[0].addr, sq[0].wdata);
            bus.req_valid = 1'b1;
            rdy = 1'b1;
            for (int c = 0; c < 40 && nresp < 4; c++) begin
                @(posedge clk);
                #1;
                if (rdy) begin
                    acc++;
                    if (acc < 4) drive(sq[acc].wr, sq[acc].sz, sq[acc].uns, sq[acc].addr, sq[acc].wdata);
                    else bus.req_valid = 1'b0;
                end
                @(negedge clk);
                if (bus.resp_valid) begin
                    chk($sformatf("strm_r%0d_rdata", nresp), bus.resp_rdata, sexp[nresp]);
                    chk($sformatf("strm_r%0d_err", nresp), 32'(bus.resp_error), 32'd0);
                    nresp++;
                end
                rdy = bus.req_ready && bus.req_valid;
            end
            bus.req_valid = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (bus.resp_valid) extra++;
            end
            chk("strm_accepts",  32'(acc),   32'd4);
            chk("strm_resps",    32'(nresp), 32'd4);
            chk("strm_no_extra", 32'(extra), 32'd0);
            chk("strm_mem8",     mem[8],     32'h1111AA11);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator side of the data-memory interface. Sits between the CPU load/store stage and the word-addressed data memory.
- Accepts byte, halfword and word load/store requests on a valid/ready handshake.
- Drives the memory's address, write-data, write-enable and read-enable signals, using read-modify-write for sub-word stores.
- Returns load data (sign- or zero-extended) or an error response on a one-cycle response strobe.

Parameters:
- DEPTH, 256, number of 32-bit words in the attached data memory; word index must be < DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the value occupies the low bits.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  qualifies resp_valid; set on misaligned, illegal-size or out-of-range requests.
- mem_address  output  32  word index = captured req_addr >> 2.
- mem_data_in  output  32  write word to memory.
- mem_write  output  1  memory write enable; the memory writes on the rising clk edge.
- mem_read  output  1  memory read enable; read data is combinational, same cycle.
- mem_data_out  input  32  read word from memory.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; all request registers cleared.
  - req_ready = 1 once rst deasserts; it is 0 while rst is high.
  - resp_valid, resp_error, resp_rdata, mem_write, mem_read, mem_address and mem_data_in are all 0.
- Memory-side outputs are decoded from the registered state and registered request only, never from req_* inputs directly.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - On acceptance, addr, size, write, unsigned and wdata are captured.
  - req_* inputs are ignored outside IDLE.
- States: IDLE, READ, WRITE, RESP.
- Error check at acceptance. Any of the following sends the FSM IDLE -> RESP with resp_error = 1 and resp_rdata = 0, and neither mem_read nor mem_write is ever asserted:
  - size 11;
  - halfword with addr[0] != 0;
  - word with addr[1:0] != 0;
  - (addr >> 2) >= DEPTH.
- Load: IDLE -> READ -> RESP.
  - In READ: mem_read = 1 and mem_address is driven; mem_data_out is captured at the end of the cycle.
  - In RESP: resp_valid = 1 with the extracted, extended data.
  - Latency: resp_valid is high 2 cycles after the accept edge.
- Word store: IDLE -> WRITE -> RESP.
  - In WRITE: mem_write = 1 and mem_data_in = wdata.
  - Latency: 2 cycles.
- Sub-word store: IDLE -> READ -> WRITE -> RESP.
  - READ captures the old word.
  - WRITE drives the merged word: only the addressed byte/halfword lane is replaced by wdata[7:0] or wdata[15:0]; other lanes are preserved.
  - Latency: 3 cycles.
- Byte lanes are little-endian: addr[1:0] = 0 selects bits 7:0, 3 selects bits 31:24. Halfword addr[1] = 0 selects bits 15:0, 1 selects bits 31:16.
- Sign extension replicates bit 7 (byte) or bit 15 (halfword). Word loads ignore req_unsigned.
- RESP lasts exactly one cycle, then returns to IDLE. req_ready is 0 during RESP, so back-to-back throughput is one request per 3 or 4 cycles.
- mem_write is high for exactly one cycle per store; mem_read and mem_write are never high together.
- Reset mid-operation: all outputs drop immediately.
  - If rst rises before the WRITE-state clock edge, no memory write occurs.
  - The pending request is discarded and no response is produced.

Test Plan:
- Preload word[4] = 0x8899AABB. Signed byte load at addr 0x13 -> resp_valid 2 cycles after accept, resp_rdata = 0xFFFFFF88, resp_error = 0; mem_read high 1 cycle with mem_address = 4.
- Unsigned byte load at addr 0x13 -> 0x00000088. Signed halfword load at 0x12 -> 0xFFFF8899. Word load at 0x10 -> 0x8899AABB.
- Byte store wdata 0x12345678 at addr 0x11 -> READ then WRITE; mem_data_in = 0x889978BB with mem_write high for exactly 1 cycle; response 3 cycles after accept with rdata = 0. A following word load at 0x10 returns 0x889978BB.
- Halfword load at 0x11, word store at 0x12, size 11, and word load at 0x400 (index 256) -> each gives resp_valid = 1, resp_error = 1 one cycle after accept, with no mem_read/mem_write pulse. Memory is unchanged.
- Word store 0xDEADBEEF at 0x10 with rst asserted during the WRITE cycle before the edge -> mem_write drops at once, word[4] is unchanged, no resp_valid, and req_ready = 1 after rst releases.
- Hold req_valid high continuously with alternating load/store requests -> each request is accepted only in IDLE, no request is lost or duplicated, and responses appear in issue order.
